// File: rtl/frame_cfg_pkg.sv
// Shared constants for the frame-configuration write path: sync/opcode values,
// header field positions and FSM state encodings.
package frame_cfg_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_DESYNC = 8'h02;

    // Header word layout: opcode | start frame | frame count | column
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 24;
    localparam int START_MSB = 23;
    localparam int START_LSB = 16;
    localparam int COUNT_MSB = 15;
    localparam int COUNT_LSB = 8;
    localparam int COL_MSB   = 7;
    localparam int COL_LSB   = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_STROBE = 2'd3;

endpackage

// File: rtl/frame_config_writer_decoder.sv
// Binary frame index to one-hot frame latch strobe; indices beyond the
// column's frame count decode to no strobe at all.
module frame_strobe_decoder #(
    parameter int FRAMES_PER_COL = 20
) (
    input  logic [7:0]                idx,
    input  logic                      en,
    output logic [FRAMES_PER_COL-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int i = 0; i < FRAMES_PER_COL; i++) begin
            strobe[i] = en && (idx == 8'(i));
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Turns a 32-bit configuration word stream into FrameData writes plus one-hot
// FrameStrobe pulses: sync detect, header decode, range check, desync.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int NUM_COLS       = 16,
    parameter int FRAMES_PER_COL = 20,
    parameter int COL_W          = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [31:0]               s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [31:0]               frame_data,
    output logic [COL_W-1:0]          frame_col,
    output logic [FRAMES_PER_COL-1:0] frame_strobe,
    output logic                      busy,
    output logic                      cfg_err,
    output logic                      cfg_done,
    output logic [1:0]                dbg_state
);

    logic [1:0] state;
    logic [7:0] idx;
    logic [7:0] remaining;
    logic       accept;

    logic [7:0] hdr_op;
    logic [7:0] hdr_start;
    logic [7:0] hdr_count;
    logic [7:0] hdr_col;
    logic [8:0] hdr_end;
    logic       hdr_bad;

    // Handshake: a word transfers on the rising edge where s_valid && s_ready.
    // s_ready depends only on reset and state (low for the single STROBE cycle),
    // never on s_valid, so the source may hold or drop s_valid at will.
    assign s_ready = !reset && (state != ST_STROBE);
    assign accept  = s_valid && s_ready;

    assign hdr_op    = s_data[OP_MSB:OP_LSB];
    assign hdr_start = s_data[START_MSB:START_LSB];
    assign hdr_count = s_data[COUNT_MSB:COUNT_LSB];
    assign hdr_col   = s_data[COL_MSB:COL_LSB];

    // 9-bit sum so a start near 255 cannot wrap back into the legal range
    assign hdr_end = {1'b0, hdr_start} + {1'b0, hdr_count};
    assign hdr_bad = (hdr_count == 8'd0)
                  || ({1'b0, hdr_col} >= 9'(NUM_COLS))
                  || (hdr_end > 9'(FRAMES_PER_COL));

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 8'd0;
            remaining  <= 8'd0;
            frame_data <= 32'd0;
            frame_col  <= '0;
            cfg_err    <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && (s_data == SYNC_WORD)) begin
                        cfg_err <= 1'b0;
                        state   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        if (hdr_op == OP_WRITE) begin
                            if (hdr_bad) begin
                                cfg_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                frame_col <= COL_W'(hdr_col);
                                idx       <= hdr_start;
                                remaining <= hdr_count;
                                state     <= ST_LOAD;
                            end
                        end else if (hdr_op == OP_DESYNC) begin
                            cfg_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        frame_data <= s_data;
                        state      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    idx       <= idx + 8'd1;
                    remaining <= remaining - 8'd1;
                    state     <= (remaining == 8'd1) ? ST_HEADER : ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gating with reset keeps a pending strobe from escaping in a reset cycle
    frame_strobe_decoder #(
        .FRAMES_PER_COL(FRAMES_PER_COL)
    ) u_decoder (
        .idx    (idx),
        .en     ((state == ST_STROBE) && !reset),
        .strobe (frame_strobe)
    );

endmodule
